// File: rtl/dctq_row_ctrl.sv
// Sequencing controller for the DCTQ 8-entry row-collection register.
// Addresses serial samples into the register and hands completed rows to the 1-D DCT stage.
module dctq_row_ctrl #(
    parameter int WIDTH = 11,
    parameter int ROWS  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIDTH-1:0] reg_din,
    output logic [2:0]       reg_wa,
    output logic             reg_en,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [7:0]       row_idx,
    output logic             row_last,
    output logic             err_misalign
);

    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    logic [2:0]    col;
    logic [RW-1:0] row;
    logic          accept;
    logic          sof_acc;
    logic          xfer;
    logic          consume;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready never depends on valid, and a valid source holds its
    // payload stable until that transfer.
    always_comb begin
        in_ready = 1'b0;
        if (col != 3'd7 || !row_valid || row_ready || in_sof) begin
            in_ready = 1'b1;
        end
    end

    // Column 7 is the transfer write; a start-of-frame sample always lands in entry 0
    // so it never overwrites the row still presented downstream.
    always_comb begin
        accept  = in_valid & in_ready;
        sof_acc = accept & in_sof;
        xfer    = accept & ~in_sof & (col == 3'd7);
        consume = row_valid & row_ready;
        reg_en  = accept;
        reg_din = in_data;
        reg_wa  = (in_valid && in_sof) ? 3'd0 : col;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col          <= 3'd0;
            row          <= '0;
            err_misalign <= 1'b0;
        end else begin
            err_misalign <= 1'b0;
            if (sof_acc) begin
                col          <= 3'd1;
                row          <= '0;
                err_misalign <= (col != 3'd0) || (row != '0);
            end else if (accept) begin
                col <= col + 3'd1;
                if (xfer) begin
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end
            end
        end
    end

    // A transfer in the consume cycle refills the output without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_valid <= 1'b0;
            row_idx   <= 8'd0;
            row_last  <= 1'b0;
        end else if (xfer) begin
            row_valid <= 1'b1;
            row_idx   <= 8'(row);
            row_last  <= (row == ROW_MAX);
        end else if (consume) begin
            row_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dctq_row_ctrl.sv
// Directed bench for dctq_row_ctrl: sample driver with a column/row model,
// and a row scoreboard popped whenever the DUT hands off a row.
module tb_dctq_row_ctrl;

    localparam int W    = 11;
    localparam int ROWS = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_sof;
    logic         in_ready;
    logic [W-1:0] reg_din;
    logic [2:0]   reg_wa;
    logic         reg_en;
    logic         row_valid;
    logic         row_ready;
    logic [7:0]   row_idx;
    logic         row_last;
    logic         err_misalign;

    int checks = 0;
    int errors = 0;
    int exp_col = 0;
    int exp_row = 0;
    int stall_cnt = 0;
    logic [8:0] exp_q[$];

    dctq_row_ctrl #(.WIDTH(W), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .reg_din(reg_din), .reg_wa(reg_wa), .reg_en(reg_en),
        .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
        .row_last(row_last), .err_misalign(err_misalign)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; row_ready = 1'b0; in_data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_col = 0; exp_row = 0; stall_cnt = 0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_reg_wa", reg_wa, 0);
        check("rst_reg_en", reg_en, 0);
        check("rst_row_valid", row_valid, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_last", row_last, 0);
        check("rst_err", err_misalign, 0);
    endtask

    // driver: present one sample, wait (bounded) for acceptance, update model
    task automatic send(input logic [W-1:0] d, input logic sof);
        int waits;
        logic [2:0] wa;
        logic exp_err;
        in_data = d; in_sof = sof; in_valid = 1'b1;
        #1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++; stall_cnt++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        wa = sof ? 3'd0 : 3'(exp_col);
        check("reg_wa", reg_wa, wa);
        check("reg_en", reg_en, 1);
        check("reg_din", reg_din, d);
        exp_err = sof && (exp_col != 0 || exp_row != 0);
        if (sof) begin
            exp_col = 1; exp_row = 0;
        end else begin
            if (exp_col == 7) begin
                exp_q.push_back({exp_row == ROWS - 1, 8'(exp_row)});
                exp_row = (exp_row + 1) % ROWS;
            end
            exp_col = (exp_col + 1) % 8;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        check("err_misalign", err_misalign, exp_err);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_sof = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // scoreboard: a row leaves the DUT when row_valid & row_ready at the edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && row_valid === 1'b1 && row_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("row_unexpected", row_valid, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("row_idx", row_idx, e[7:0]);
                check("row_last", row_last, e[8]);
            end
        end
    end

    initial begin
        // 64-sample stream, row_ready high: no stalls, rows 0..7
        reset_dut();
        row_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(W'(i), 1'b0);
        idle(2);
        check("t1_stalls", stall_cnt, 0);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_row_valid", row_valid, 0);

        // row 0 pending with row_ready low; staging samples still accepted
        reset_dut();
        for (int i = 0; i < 15; i++) send(W'(i), 1'b0);
        in_data = W'(15); in_valid = 1'b1; in_sof = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_reg_en", reg_en, 0);
            check("stall_row_valid", row_valid, 1);
            check("stall_row_idx", row_idx, 0);
            check("stall_row_last", row_last, 0);
            @(posedge clk); #1;
        end
        row_ready = 1'b1;
        send(W'(15), 1'b0);
        check("b2b_row_valid", row_valid, 1);
        check("b2b_row_idx", row_idx, 1);
        idle(2);
        check("t2_q_empty", exp_q.size(), 0);
        check("t2_row_valid", row_valid, 0);

        // in_sof on 4th sample of row 2
        reset_dut();
        row_ready = 1'b1;
        for (int i = 0; i < 19; i++) send(W'($urandom_range(0, 2047)), 1'b0);
        send(W'(100), 1'b1);
        for (int i = 0; i < 7; i++) send(W'($urandom_range(0, 2047)), 1'b0);
        idle(2);
        check("t4_q_empty", exp_q.size(), 0);

        // aligned in_sof, then in_sof without in_valid
        reset_dut();
        row_ready = 1'b1;
        send(W'(7), 1'b1);
        in_sof = 1'b1; in_valid = 1'b0;
        #1;
        check("sof_novalid_en", reg_en, 0);
        @(posedge clk); #1;
        in_sof = 1'b0;
        #1;
        check("sof_novalid_wa", reg_wa, 1);
        check("sof_novalid_err", err_misalign, 0);
        for (int i = 0; i < 7; i++) send(W'(i + 1), 1'b0);
        idle(2);
        check("t5_q_empty", exp_q.size(), 0);

        // in_sof at col 7 while the row is stalled
        reset_dut();
        for (int i = 0; i < 15; i++) send(W'(i), 1'b0);
        in_data = W'(15); in_valid = 1'b1; in_sof = 1'b0;
        #1;
        check("c7_in_ready", in_ready, 0);
        stall_cnt = 0;
        send(W'(200), 1'b1);
        check("c7_sof_stalls", stall_cnt, 0);
        check("c7_row_valid", row_valid, 1);
        check("c7_row_idx", row_idx, 0);
        row_ready = 1'b1;
        idle(2);
        check("t7_q_empty", exp_q.size(), 0);

        // reset mid-row with a pending row
        reset_dut();
        for (int i = 0; i < 11; i++) send(W'(i), 1'b0);
        check("pre_rst_row_valid", row_valid, 1);
        reset_dut();
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(W'(i + 40), 1'b0);
        idle(2);
        check("t6_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
